// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results with buffered late
// (load/divide) results into one register-file write port, and tracks
// pending late destinations so ID can stall on RAW/WAW hazards.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef RF_AWIDTH
`define RF_AWIDTH 5
`endif
`ifndef RF_SIZE
`define RF_SIZE 32
`endif

module wb_arbiter #(
  parameter int LATE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exe2wb_valid_i,
  input  logic [`RF_AWIDTH-1:0] exe2wb_rd_addr_i,
  input  logic [`XLEN-1:0]      exe2wb_rd_data_i,
  input  logic                  lsu2wb_valid_i,
  input  logic [`RF_AWIDTH-1:0] lsu2wb_rd_addr_i,
  input  logic [`XLEN-1:0]      lsu2wb_rd_data_i,
  output logic                  wb2lsu_ready_o,
  input  logic                  id2wb_issue_i,
  input  logic [`RF_AWIDTH-1:0] id2wb_issue_rd_i,
  input  logic [`RF_AWIDTH-1:0] id2wb_rs1_addr_i,
  input  logic [`RF_AWIDTH-1:0] id2wb_rs2_addr_i,
  input  logic [`RF_AWIDTH-1:0] id2wb_rd_addr_i,
  output logic                  wb2id_stall_o,
  output logic                  wb2rf_rd_wr_req_o,
  output logic [`RF_AWIDTH-1:0] wb2rf_rd_addr_o,
  output logic [`XLEN-1:0]      wb2rf_rd_data_o
);

  localparam int PW = (LATE_DEPTH > 1) ? $clog2(LATE_DEPTH) : 1;
  localparam int CW = $clog2(LATE_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(LATE_DEPTH);

  logic [`RF_AWIDTH-1:0] late_addr [LATE_DEPTH];
  logic [`XLEN-1:0]      late_data [LATE_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [`RF_SIZE-1:0]   pending;
  logic [`RF_SIZE-1:0]   pending_next;
  logic                  push;
  logic                  pop;
  logic [`RF_AWIDTH-1:0] head_addr;
  logic [`XLEN-1:0]      head_data;

  // ready depends only on the registered count, so it never loops back through LSU logic
  assign wb2lsu_ready_o = (count < DEPTH_C);
  assign push           = lsu2wb_valid_i && wb2lsu_ready_o;
  assign pop            = !exe2wb_valid_i && (count != '0);
  assign head_addr      = late_addr[rd_ptr];
  assign head_data      = late_data[rd_ptr];

  // Late-result storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      late_addr[wr_ptr] <= lsu2wb_rd_addr_i;
      late_data[wr_ptr] <= lsu2wb_rd_data_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because depth is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered RF write port: ALU wins, otherwise drain the oldest late result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb2rf_rd_wr_req_o <= 1'b0;
      wb2rf_rd_addr_o   <= '0;
      wb2rf_rd_data_o   <= '0;
    end else if (exe2wb_valid_i) begin
      wb2rf_rd_wr_req_o <= 1'b1;
      wb2rf_rd_addr_o   <= exe2wb_rd_addr_i;
      wb2rf_rd_data_o   <= exe2wb_rd_data_i;
    end else if (pop) begin
      wb2rf_rd_wr_req_o <= 1'b1;
      wb2rf_rd_addr_o   <= head_addr;
      wb2rf_rd_data_o   <= head_data;
    end else begin
      wb2rf_rd_wr_req_o <= 1'b0;
    end
  end

  // Next pending set: clear on pop first, then apply issue so a same-cycle re-issue stays set
  always_comb begin
    pending_next = pending;
    if (pop) pending_next[head_addr] = 1'b0;
    if (id2wb_issue_i && (id2wb_issue_rd_i != '0)) pending_next[id2wb_issue_rd_i] = 1'b1;
  end

  // Scoreboard register holding destinations with a late result still outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_next;
  end

  // Hazard detect against the instruction in ID; x0 never causes a stall
  always_comb begin
    wb2id_stall_o = ((id2wb_rs1_addr_i != '0) && pending[id2wb_rs1_addr_i]) ||
                    ((id2wb_rs2_addr_i != '0) && pending[id2wb_rs2_addr_i]) ||
                    ((id2wb_rd_addr_i  != '0) && pending[id2wb_rd_addr_i]);
  end

endmodule
